// File: rtl/vending_ctrl.sv
// -----------------------------------------------------------------------------
// vending_ctrl
//
// Purpose
//   Coin-operated vending controller. It accumulates credit from coin strobes,
//   vends an item when the selection is affordable, and hands any change (or a
//   full refund on cancel) to an external change dispenser. The dispenser
//   reports completion with chg_done.
//
// Optional feature
//   VEND_TIMEOUT_EN : when defined, an idle counter in COLLECT triggers an
//                     automatic refund after TIMEOUT_CYC quiet cycles. When it
//                     is undefined, no counter exists and COLLECT waits forever.
//
// Ports
//   sclk        in   system clock, rising edge
//   srst_n      in   asynchronous active-low reset
//   coin_valid  in   one-cycle coin strobe, coin code on coin_val
//   coin_val    in   [1:0] 00=1, 01=5, 10=10, 11=25 units
//   sel_valid   in   one-cycle select strobe, item index on sel_item
//   sel_item    in   [1:0] item index
//   cancel      in   one-cycle refund request
//   chg_done    in   one-cycle pulse from dispenser: payout complete
//   credit      out  [7:0] accumulated credit
//   coin_reject out  one-cycle pulse: coin refused
//   sel_nack    out  one-cycle pulse: selection refused
//   vend        out  one-cycle dispense pulse
//   vend_item   out  [1:0] item index, valid while vend=1
//   chg_start   out  one-cycle pulse: start paying chg_amount
//   chg_amount  out  [7:0] change value, held from chg_start until chg_done
//   busy        out  high in VEND, CHANGE and WAIT_CHG
//
// Handshake: every input is a single-cycle strobe sampled on the rising edge;
// there is no back-pressure. Each strobe produces either its effect or a
// one-cycle refusal pulse (coin_reject / sel_nack) registered on the same
// edge, or is silently dropped where noted. All outputs are registered.
//
// The FSM state is held in the enum signal `state` for observation.
// -----------------------------------------------------------------------------
module vending_ctrl #(
    parameter int PRICE0      = 25,
    parameter int PRICE1      = 50,
    parameter int PRICE2      = 75,
    parameter int PRICE3      = 110,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       sclk,
    input  logic       srst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_val,
    input  logic       sel_valid,
    input  logic [1:0] sel_item,
    input  logic       cancel,
    input  logic       chg_done,
    output logic [7:0] credit,
    output logic       coin_reject,
    output logic       sel_nack,
    output logic       vend,
    output logic [1:0] vend_item,
    output logic       chg_start,
    output logic [7:0] chg_amount,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        VEND     = 3'd2,
        CHANGE   = 3'd3,
        WAIT_CHG = 3'd4
    } state_t;

    state_t state;

    // Cleared by reset, set on the first edge afterwards: inputs are only
    // acted on from the second rising edge after reset release.
    logic armed;

    localparam logic [7:0] PRICE0_8 = PRICE0[7:0];
    localparam logic [7:0] PRICE1_8 = PRICE1[7:0];
    localparam logic [7:0] PRICE2_8 = PRICE2[7:0];
    localparam logic [7:0] PRICE3_8 = PRICE3[7:0];

    function automatic logic [7:0] coin_units(input logic [1:0] code);
        logic [7:0] units;
        case (code)
            2'b00:   units = 8'd1;
            2'b01:   units = 8'd5;
            2'b10:   units = 8'd10;
            default: units = 8'd25;
        endcase
        return units;
    endfunction

    function automatic logic [7:0] item_price(input logic [1:0] idx);
        logic [7:0] price;
        case (idx)
            2'd0:    price = PRICE0_8;
            2'd1:    price = PRICE1_8;
            2'd2:    price = PRICE2_8;
            default: price = PRICE3_8;
        endcase
        return price;
    endfunction

    // One extra bit catches a coin that would push credit past 255.
    logic [8:0] coin_sum;
    logic       coin_fits;
    logic [7:0] sel_price;
    logic       sel_ok;
    logic       any_event;
    logic       timeout_hit;

    assign coin_sum  = {1'b0, credit} + {1'b0, coin_units(coin_val)};
    assign coin_fits = ~coin_sum[8];
    assign sel_price = item_price(sel_item);
    assign sel_ok    = (credit >= sel_price);
    assign any_event = coin_valid | sel_valid | cancel;

`ifdef VEND_TIMEOUT_EN
    localparam int             CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC);

    // Counts quiet COLLECT cycles; any strobe restarts it. It saturates at
    // TIMEOUT_CYC, and a quiet cycle seen at that value acts as a cancel.
    logic [CNT_W-1:0] idle_cnt;

    assign timeout_hit = (state == COLLECT) && !any_event && (idle_cnt == CNT_LAST);

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            idle_cnt <= '0;
        end else if (!armed || (state != COLLECT) || any_event) begin
            idle_cnt <= '0;
        end else if (idle_cnt != CNT_LAST) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state       <= IDLE;
            armed       <= 1'b0;
            credit      <= 8'd0;
            chg_amount  <= 8'd0;
            vend_item   <= 2'd0;
            vend        <= 1'b0;
            chg_start   <= 1'b0;
            coin_reject <= 1'b0;
            sel_nack    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            armed       <= 1'b1;
            // Pulse outputs default low; the branches below raise them for
            // exactly one cycle.
            vend        <= 1'b0;
            chg_start   <= 1'b0;
            coin_reject <= 1'b0;
            sel_nack    <= 1'b0;

            if (armed) begin
                case (state)
                    IDLE: begin
                        // sel_valid and cancel carry no meaning without credit.
                        if (coin_valid) begin
                            credit <= coin_units(coin_val);
                            state  <= COLLECT;
                        end
                    end

                    COLLECT: begin
                        // Priority: cancel (or timeout) > coin > select.
                        if (cancel || timeout_hit) begin
                            chg_amount <= credit;
                            chg_start  <= 1'b1;
                            busy       <= 1'b1;
                            state      <= CHANGE;
                        end else if (coin_valid) begin
                            if (coin_fits) begin
                                credit <= coin_sum[7:0];
                            end else begin
                                coin_reject <= 1'b1;
                            end
                        end else if (sel_valid) begin
                            if (sel_ok) begin
                                vend       <= 1'b1;
                                vend_item  <= sel_item;
                                chg_amount <= credit - sel_price;
                                busy       <= 1'b1;
                                state      <= VEND;
                            end else begin
                                sel_nack <= 1'b1;
                            end
                        end
                    end

                    VEND: begin
                        // Exact payment skips the dispenser entirely.
                        if (chg_amount == 8'd0) begin
                            credit <= 8'd0;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            chg_start <= 1'b1;
                            state     <= CHANGE;
                        end
                    end

                    CHANGE: begin
                        state <= WAIT_CHG;
                    end

                    WAIT_CHG: begin
                        if (chg_done) begin
                            credit     <= 8'd0;
                            chg_amount <= 8'd0;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase

                // While a transaction is in flight, coins and selections are
                // refused visibly; cancel is dropped silently.
                if (busy) begin
                    if (coin_valid) begin
                        coin_reject <= 1'b1;
                    end else if (sel_valid) begin
                        sel_nack <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vending_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vending_ctrl
//
// Self-checking bench for vending_ctrl. Pulse outputs (vend, chg_start,
// coin_reject, sel_nack) are checked by a negedge monitor against an
// expected-event queue filled by the scenario tasks before they drive the
// stimulus. Levels (credit, chg_amount, busy, state) are checked inline.
// Build with +define+VEND_TIMEOUT_EN to exercise the auto-refund.
// -----------------------------------------------------------------------------
module tb_vending_ctrl;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_COLLECT  = 3'd1;
    localparam logic [2:0] S_VEND     = 3'd2;
    localparam logic [2:0] S_CHANGE   = 3'd3;
    localparam logic [2:0] S_WAIT_CHG = 3'd4;

    // Event kinds in the expected queue: {kind[3:0], value[7:0]}
    localparam logic [3:0] EV_VEND   = 4'd1;
    localparam logic [3:0] EV_CHG    = 4'd2;
    localparam logic [3:0] EV_REJECT = 4'd3;
    localparam logic [3:0] EV_NACK   = 4'd4;

    logic       sclk;
    logic       srst_n;
    logic       coin_valid;
    logic [1:0] coin_val;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       chg_done;
    logic [7:0] credit;
    logic       coin_reject;
    logic       sel_nack;
    logic       vend;
    logic [1:0] vend_item;
    logic       chg_start;
    logic [7:0] chg_amount;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [11:0] exp_q[$];

    vending_ctrl #(
        .PRICE0      (25),
        .PRICE1      (50),
        .PRICE2      (75),
        .PRICE3      (110),
        .TIMEOUT_CYC (8)
    ) dut (
        .sclk        (sclk),
        .srst_n      (srst_n),
        .coin_valid  (coin_valid),
        .coin_val    (coin_val),
        .sel_valid   (sel_valid),
        .sel_item    (sel_item),
        .cancel      (cancel),
        .chg_done    (chg_done),
        .credit      (credit),
        .coin_reject (coin_reject),
        .sel_nack    (sel_nack),
        .vend        (vend),
        .vend_item   (vend_item),
        .chg_start   (chg_start),
        .chg_amount  (chg_amount),
        .busy        (busy)
    );

    // ---------------- clock / reset ----------------
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge sclk) begin
        logic [11:0] obs[$];
        logic [11:0] exp_ev;
        obs = {};
        if (vend)        obs.push_back({EV_VEND, 6'd0, vend_item});
        if (chg_start)   obs.push_back({EV_CHG, chg_amount});
        if (coin_reject) obs.push_back({EV_REJECT, 8'd0});
        if (sel_nack)    obs.push_back({EV_NACK, 8'd0});
        foreach (obs[i]) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_event at %0t: got=%h required=none", $time, obs[i]);
            end else begin
                exp_ev = exp_q.pop_front();
                if (obs[i] !== exp_ev) begin
                    errors++;
                    $display("FAIL sb_event at %0t: got=%h required=%h", $time, obs[i], exp_ev);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers start and end on a falling edge.
    task automatic drive_cycle(input logic cv, input logic [1:0] cc, input logic sv,
                               input logic [1:0] si, input logic cn, input logic cd);
        coin_valid = cv;
        coin_val   = cc;
        sel_valid  = sv;
        sel_item   = si;
        cancel     = cn;
        chg_done   = cd;
        @(negedge sclk);
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        cancel     = 1'b0;
        chg_done   = 1'b0;
    endtask

    task automatic insert_coin(input logic [1:0] code);
        drive_cycle(1'b1, code, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic select_item(input logic [1:0] item);
        drive_cycle(1'b0, 2'd0, 1'b1, item, 1'b0, 1'b0);
    endtask

    task automatic press_cancel();
        drive_cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    endtask

    task automatic pulse_done();
        drive_cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    // Entered in CHANGE: an early chg_done must be ignored, the next one
    // (in WAIT_CHG) returns to IDLE with credit cleared.
    task automatic finish_payout(input logic [7:0] amt);
        pulse_done();
        checks++;
        if (dut.state !== S_WAIT_CHG || chg_amount !== amt || busy !== 1'b1) begin
            errors++;
            $display("FAIL payout_wait: state=%0d chg_amount=%0d busy=%b required state=%0d chg_amount=%0d busy=1",
                     dut.state, chg_amount, busy, S_WAIT_CHG, amt);
        end
        pulse_done();
        checks++;
        if (dut.state !== S_IDLE || credit !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL payout_done: state=%0d credit=%0d busy=%b required state=0 credit=0 busy=0",
                     dut.state, credit, busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        srst_n = 1'b0;
        idle_cycles(3);
        checks++;
        if ({credit, chg_amount, vend_item, vend, chg_start, coin_reject, sel_nack, busy} !== 22'd0
            || dut.state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_values: credit=%0d chg_amount=%0d vend_item=%0d pulses=%b%b%b%b busy=%b state=%0d required all 0",
                     credit, chg_amount, vend_item, vend, chg_start, coin_reject, sel_nack, busy, dut.state);
        end
        // A coin on the first edge after release is not yet accepted.
        srst_n = 1'b1;
        insert_coin(2'b11);
        checks++;
        if (credit !== 8'd0 || dut.state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_first_edge: credit=%0d state=%0d required credit=0 state=0", credit, dut.state);
        end
        insert_coin(2'b00);
        checks++;
        if (credit !== 8'd1 || dut.state !== S_COLLECT) begin
            errors++;
            $display("FAIL reset_second_edge: credit=%0d state=%0d required credit=1 state=1", credit, dut.state);
        end
        exp_q.push_back({EV_CHG, 8'd1});
        press_cancel();
        finish_payout(8'd1);
    endtask

    task automatic test_idle_ignore();
        select_item(2'd2);
        press_cancel();
        checks++;
        if (dut.state !== S_IDLE || credit !== 8'd0) begin
            errors++;
            $display("FAIL idle_ignore: state=%0d credit=%0d required state=0 credit=0", dut.state, credit);
        end
    endtask

    task automatic test_vend_with_change();
        insert_coin(2'b11);
        insert_coin(2'b11);
        insert_coin(2'b00);
        checks++;
        if (credit !== 8'd51) begin
            errors++;
            $display("FAIL vend_credit: credit=%0d required 51", credit);
        end
        exp_q.push_back({EV_VEND, 8'd1});
        exp_q.push_back({EV_CHG, 8'd1});
        select_item(2'd1);
        checks++;
        if (dut.state !== S_VEND || busy !== 1'b1 || chg_amount !== 8'd1) begin
            errors++;
            $display("FAIL vend_state: state=%0d busy=%b chg_amount=%0d required state=2 busy=1 chg_amount=1",
                     dut.state, busy, chg_amount);
        end
        idle_cycles(1);
        checks++;
        if (dut.state !== S_CHANGE) begin
            errors++;
            $display("FAIL vend_to_change: state=%0d required %0d", dut.state, S_CHANGE);
        end
        finish_payout(8'd1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL vend_events: pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_exact_vend();
        insert_coin(2'b11);
        exp_q.push_back({EV_VEND, 8'd0});
        select_item(2'd0);
        idle_cycles(1);
        checks++;
        if (dut.state !== S_IDLE || credit !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL exact_vend: state=%0d credit=%0d busy=%b required state=0 credit=0 busy=0",
                     dut.state, credit, busy);
        end
    endtask

    task automatic test_nack_then_cancel();
        insert_coin(2'b10);
        insert_coin(2'b10);
        exp_q.push_back({EV_NACK, 8'd0});
        select_item(2'd0);
        checks++;
        if (credit !== 8'd20 || dut.state !== S_COLLECT) begin
            errors++;
            $display("FAIL nack_credit: credit=%0d state=%0d required credit=20 state=1", credit, dut.state);
        end
        exp_q.push_back({EV_CHG, 8'd20});
        press_cancel();
        checks++;
        if (chg_amount !== 8'd20 || dut.state !== S_CHANGE) begin
            errors++;
            $display("FAIL cancel_refund: chg_amount=%0d state=%0d required chg_amount=20 state=3",
                     chg_amount, dut.state);
        end
        finish_payout(8'd20);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) insert_coin(2'b11);
        insert_coin(2'b10);
        insert_coin(2'b01);
        checks++;
        if (credit !== 8'd240) begin
            errors++;
            $display("FAIL ovf_build: credit=%0d required 240", credit);
        end
        exp_q.push_back({EV_REJECT, 8'd0});
        insert_coin(2'b11);
        checks++;
        if (credit !== 8'd240) begin
            errors++;
            $display("FAIL ovf_reject: credit=%0d required 240", credit);
        end
        insert_coin(2'b10);
        checks++;
        if (credit !== 8'd250) begin
            errors++;
            $display("FAIL ovf_accept: credit=%0d required 250", credit);
        end
        insert_coin(2'b01);
        exp_q.push_back({EV_REJECT, 8'd0});
        insert_coin(2'b00);
        checks++;
        if (credit !== 8'd255) begin
            errors++;
            $display("FAIL ovf_max: credit=%0d required 255", credit);
        end
        exp_q.push_back({EV_CHG, 8'd255});
        press_cancel();
        checks++;
        if (chg_amount !== 8'd255) begin
            errors++;
            $display("FAIL ovf_refund: chg_amount=%0d required 255", chg_amount);
        end
        finish_payout(8'd255);
    endtask

    task automatic test_priority();
        insert_coin(2'b11);
        insert_coin(2'b11);
        exp_q.push_back({EV_CHG, 8'd50});
        drive_cycle(1'b1, 2'b11, 1'b1, 2'd1, 1'b1, 1'b0);
        checks++;
        if (dut.state !== S_CHANGE || chg_amount !== 8'd50 || credit !== 8'd50) begin
            errors++;
            $display("FAIL priority: state=%0d chg_amount=%0d credit=%0d required state=3 chg_amount=50 credit=50",
                     dut.state, chg_amount, credit);
        end
        finish_payout(8'd50);
    endtask

    task automatic test_busy_and_reset();
        insert_coin(2'b11);
        insert_coin(2'b01);
        pulse_done();
        checks++;
        if (dut.state !== S_COLLECT || credit !== 8'd30) begin
            errors++;
            $display("FAIL done_ignored: state=%0d credit=%0d required state=1 credit=30", dut.state, credit);
        end
        exp_q.push_back({EV_CHG, 8'd30});
        press_cancel();
        idle_cycles(1);
        exp_q.push_back({EV_REJECT, 8'd0});
        insert_coin(2'b11);
        exp_q.push_back({EV_NACK, 8'd0});
        select_item(2'd0);
        press_cancel();
        checks++;
        if (dut.state !== S_WAIT_CHG || credit !== 8'd30 || chg_amount !== 8'd30) begin
            errors++;
            $display("FAIL busy_hold: state=%0d credit=%0d chg_amount=%0d required state=4 credit=30 chg_amount=30",
                     dut.state, credit, chg_amount);
        end
        srst_n = 1'b0;
        #1;
        checks++;
        if ({credit, chg_amount, vend_item, vend, chg_start, coin_reject, sel_nack, busy} !== 22'd0
            || dut.state !== S_IDLE) begin
            errors++;
            $display("FAIL midreset: credit=%0d chg_amount=%0d busy=%b state=%0d required all 0",
                     credit, chg_amount, busy, dut.state);
        end
        @(negedge sclk);
        srst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_timeout();
        int waited;
        bit seen;
        insert_coin(2'b01);
`ifdef VEND_TIMEOUT_EN
        exp_q.push_back({EV_CHG, 8'd5});
        waited = 0;
        seen   = 1'b0;
        // Eight quiet cycles reach the limit; the refund takes effect on the
        // following edge, so chg_start is seen on the ninth falling edge.
        for (int i = 1; i <= 30; i++) begin
            idle_cycles(1);
            if (chg_start) begin
                waited = i;
                seen   = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || waited != 9 || chg_amount !== 8'd5) begin
            errors++;
            $display("FAIL timeout_refund: seen=%b after=%0d chg_amount=%0d required seen=1 after=9 chg_amount=5",
                     seen, waited, chg_amount);
        end
        if (seen) finish_payout(8'd5);
`else
        waited = 40;
        seen   = 1'b0;
        idle_cycles(waited);
        checks++;
        if (dut.state !== S_COLLECT || credit !== 8'd5) begin
            errors++;
            $display("FAIL no_timeout: state=%0d credit=%0d required state=1 credit=5", dut.state, credit);
        end
        exp_q.push_back({EV_CHG, 8'd5});
        press_cancel();
        finish_payout(8'd5);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        srst_n     = 1'b0;
        coin_valid = 1'b0;
        coin_val   = 2'd0;
        sel_valid  = 1'b0;
        sel_item   = 2'd0;
        cancel     = 1'b0;
        chg_done   = 1'b0;
        @(negedge sclk);

        test_reset();
        test_idle_ignore();
        test_vend_with_change();
        test_exact_vend();
        test_nack_then_cancel();
        test_overflow();
        test_priority();
        test_busy_and_reset();
        test_timeout();

        idle_cycles(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: pending=%0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
